ram512_bist: RTL and testbench
==============================

Name: ram512_bist

Overview:
- Built-in self-test initiator for the RAM512 memory block: drives RAM512's in/load/address port and checks its out.
- On a start pulse it writes a deterministic pattern to all 512 words, reads every word back, and compares each readback against the expected pattern.
- Reports pass/fail, the error count and the first failing address/data.
- Sits beside RAM512 in the hardware-platform tree as the synthesizable counterpart of the memory bench.

Parameters:
ADDR_W, 9, address width; depth = 2**ADDR_W (512)
DATA_W, 16, data word width

Ports:
CLK  input  1  system clock, rising edge
RESET_N  input  1  asynchronous active-low reset
start  input  1  begin a test run; sampled in IDLE and DONE only
pattern_sel  input  2  pattern select, latched when start is accepted
ram_in  output  DATA_W  write data to RAM512 in
ram_load  output  1  write enable to RAM512 load
ram_address  output  ADDR_W  address to RAM512 address
ram_out  input  DATA_W  RAM512 out (combinational read of ram_address)
busy  output  1  high in WRITE or READ
done  output  1  high in DONE
pass  output  1  valid in DONE; 1 iff error_count == 0
error_count  output  ADDR_W+1  number of mismatching words (max 512, no saturation needed)
first_fail_addr  output  ADDR_W  address of first mismatch
first_fail_data  output  DATA_W  ram_out value at first mismatch

Behaviour:
- Reset (async assert, sync release): state IDLE; ram_in=0, ram_load=0, ram_address=0, busy=0, done=0, pass=0, error_count=0, first_fail_*=0. Asserting reset mid-run drops ram_load immediately; no partial state survives.
- All outputs are registered.
- Pattern function P(a), with a zero-extended to DATA_W:
  - sel 0: P(a) = a
  - sel 1: P(a) = ~a
  - sel 2: P(a) = 16'hAAAA for even a, 16'h5555 for odd a
  - sel 3: P(a) = {a[7:0], ~a[7:0]}
- FSM states: IDLE, WRITE, READ, DONE.
- IDLE: when start=1 at a clock edge, latch pattern_sel, clear error_count and first_fail_*, and go to WRITE. Outputs for the next cycle: ram_address=0, ram_in=P(0), ram_load=1.
- WRITE: one word per cycle.
  - Each edge increments ram_address and updates ram_in=P(next address).
  - On the edge where ram_address==511 (that word is committed into the RAM): go to READ with ram_address=0 and ram_load=0.
  - Lasts exactly 512 cycles.
- READ: one word per cycle.
  - At each edge compare ram_out against P(ram_address).
  - On mismatch: error_count += 1; if this is the first mismatch, capture first_fail_addr=ram_address and first_fail_data=ram_out.
  - Increment ram_address; the address wraps 511->0 on exit.
  - After the compare at 511, go to DONE.
  - Lasts exactly 512 cycles.
- DONE: done=1, busy=0, pass=(error_count==0), ram_load=0. Results hold until start=1, which restarts the run exactly as from IDLE (stats cleared, new pattern_sel latched).
- start is ignored while busy. pattern_sel changes mid-run have no effect.
- Run latency: start edge to done=1 is 1025 edges (1 + 512 + 512).
- ram_load is never high outside WRITE. No RAM write ever occurs in READ, DONE or IDLE.

Decomposition:
- Shared package ram_bist_pkg holds:
  - the state enum (IDLE/WRITE/READ/DONE)
  - pattern_sel encodings
  - the pure function pattern_word(addr, sel)
  - ADDR_W/DATA_W defaults
- No sub-module is needed for the FSM/datapath.
- Integration wrapper ram512_bist_top instantiates ram512_bist plus RAM512.

Test Plan:
- ram512_bist_top, pattern 0, start pulse -> done rises exactly 1025 edges later; pass=1, error_count=0; ram_load was high for exactly 512 cycles with ram_in==ram_address.
- Same run, with the bench forcing ram_out bit3=1 only when ram_address==100 in READ -> error_count=1, first_fail_addr=100, first_fail_data=16'd108, pass=0.
- ram_out bit0 forced to 0 for all reads, pattern 0 -> error_count=256, first_fail_addr=1, first_fail_data=0.
- Pattern 2, then start again from DONE with pattern 1 -> both pass=1; the second run's stats are cleared at the start edge, and a check confirms the RAM holds ~a afterwards.
- start pulsed repeatedly during WRITE and READ -> no restart, total latency still 1025.
- RESET_N asserted mid-WRITE at address 200 (between edges) -> ram_load=0 and all outputs at reset values immediately; after release the FSM is in IDLE and a new start completes with pass=1.

Source files
------------

// File: rtl/ram_bist_pkg.sv
// Shared definitions for the RAM512 built-in self-test: FSM states, pattern
// selector encodings and the pattern generator used on both write and compare.
package ram_bist_pkg;

    localparam int RAM_ADDR_W = 9;
    localparam int RAM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } bist_state_e;

    typedef enum logic [1:0] {
        PAT_ADDR       = 2'd0,
        PAT_INV        = 2'd1,
        PAT_CHECKER    = 2'd2,
        PAT_BYTE_SPLIT = 2'd3
    } pat_sel_e;

    // Expected word for address addr under pattern sel (addr zero-extended).
    function automatic logic [RAM_DATA_W-1:0] pattern_word(
        input logic [RAM_ADDR_W-1:0] addr,
        input pat_sel_e              sel
    );
        logic [RAM_DATA_W-1:0] a_ext;
        logic [RAM_DATA_W-1:0] word;
        a_ext = RAM_DATA_W'(addr);
        case (sel)
            PAT_ADDR:    word = a_ext;
            PAT_INV:     word = ~a_ext;
            PAT_CHECKER: word = addr[0] ? {(RAM_DATA_W/2){2'b01}} : {(RAM_DATA_W/2){2'b10}};
            default:     word = {a_ext[7:0], ~a_ext[7:0]};
        endcase
        return word;
    endfunction

endpackage

// File: rtl/RAM512.sv
// 512 x 16 memory: synchronous write on load, combinational read of address.
module RAM512 #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic [DATA_W-1:0] in,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] out
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (load) begin
            mem_q[address] <= in;
        end
    end

    assign out = mem_q[address];

endmodule

// File: rtl/ram512_bist_top.sv
// Integration wrapper: the BIST initiator wired directly to a RAM512 instance.
module ram512_bist_top
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              start,
    input  logic [1:0]        pattern_sel,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   error_count,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic [DATA_W-1:0] first_fail_data
);

    logic [DATA_W-1:0] ram_in;
    logic              ram_load;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_out;

    ram512_bist #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bist (
        .CLK             (CLK),
        .RESET_N         (RESET_N),
        .start           (start),
        .pattern_sel     (pattern_sel),
        .ram_in          (ram_in),
        .ram_load        (ram_load),
        .ram_address     (ram_address),
        .ram_out         (ram_out),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .error_count     (error_count),
        .first_fail_addr (first_fail_addr),
        .first_fail_data (first_fail_data)
    );

    RAM512 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk     (CLK),
        .in      (ram_in),
        .load    (ram_load),
        .address (ram_address),
        .out     (ram_out)
    );

endmodule

// File: rtl/ram512_bist.sv
// BIST initiator: writes a selectable pattern to every RAM512 word, reads it
// back, and reports pass/fail, error count and the first failing word.
module ram512_bist
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              start,
    input  logic [1:0]        pattern_sel,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    input  logic [DATA_W-1:0] ram_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   error_count,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic [DATA_W-1:0] first_fail_data
);

    function automatic logic [DATA_W-1:0] word_at(input logic [ADDR_W-1:0] a, input pat_sel_e s);
        return DATA_W'(pattern_word(RAM_ADDR_W'(a), s));
    endfunction

    bist_state_e       state_q;
    pat_sel_e          sel_q;
    logic [DATA_W-1:0] ram_in_q;
    logic              ram_load_q;
    logic [ADDR_W-1:0] ram_address_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [ADDR_W:0]   error_count_q;
    logic [ADDR_W-1:0] first_fail_addr_q;
    logic [DATA_W-1:0] first_fail_data_q;

    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W:0]   err_inc;
    logic [DATA_W-1:0] expect_word;
    logic [DATA_W-1:0] next_word;
    logic [DATA_W-1:0] first_word;
    logic              mismatch;
    logic              last_addr;

    assign addr_inc    = ram_address_q + 1'b1;
    assign err_inc     = error_count_q + 1'b1;
    assign expect_word = word_at(ram_address_q, sel_q);
    assign next_word   = word_at(addr_inc, sel_q);
    assign first_word  = word_at('0, pat_sel_e'(pattern_sel));
    assign mismatch    = (ram_out != expect_word);
    assign last_addr   = &ram_address_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q           <= IDLE;
            sel_q             <= PAT_ADDR;
            ram_in_q          <= '0;
            ram_load_q        <= 1'b0;
            ram_address_q     <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            error_count_q     <= '0;
            first_fail_addr_q <= '0;
            first_fail_data_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q           <= WRITE;
                        sel_q             <= pat_sel_e'(pattern_sel);
                        ram_address_q     <= '0;
                        ram_in_q          <= first_word;
                        ram_load_q        <= 1'b1;
                        busy_q            <= 1'b1;
                        done_q            <= 1'b0;
                        pass_q            <= 1'b0;
                        error_count_q     <= '0;
                        first_fail_addr_q <= '0;
                        first_fail_data_q <= '0;
                    end
                end
                WRITE: begin
                    // The word at the last address commits on this edge, so load drops here.
                    if (last_addr) begin
                        state_q       <= READ;
                        ram_address_q <= '0;
                        ram_load_q    <= 1'b0;
                    end else begin
                        ram_address_q <= addr_inc;
                        ram_in_q      <= next_word;
                    end
                end
                READ: begin
                    if (mismatch) begin
                        error_count_q <= err_inc;
                        if (error_count_q == '0) begin
                            first_fail_addr_q <= ram_address_q;
                            first_fail_data_q <= ram_out;
                        end
                    end
                    ram_address_q <= addr_inc;
                    if (last_addr) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (error_count_q == '0) && !mismatch;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_in          = ram_in_q;
    assign ram_load        = ram_load_q;
    assign ram_address     = ram_address_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign error_count     = error_count_q;
    assign first_fail_addr = first_fail_addr_q;
    assign first_fail_data = first_fail_data_q;

endmodule

// File: tb/tb_ram512_bist.sv
// Bench for ram512_bist: a bench-side RAM with read-path fault injection, a
// pattern/scoreboard model, table vectors, random runs and reset corner cases.
module tb_ram512_bist;

    localparam int DEPTH   = 512;
    localparam int EXP_LAT = 1025;  // start edge through the edge where done rises, inclusive

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [15:0] ram_in;
    logic        ram_load;
    logic [8:0]  ram_address;
    logic [15:0] ram_out;
    logic        busy, done, pass;
    logic [9:0]  error_count;
    logic [8:0]  first_fail_addr;
    logic [15:0] first_fail_data;

    logic        top_busy, top_done, top_pass;
    logic [9:0]  top_err;
    logic [8:0]  top_ffa;
    logic [15:0] top_ffd;

    always #5 CLK = ~CLK;

    ram512_bist dut (
        .CLK(CLK), .RESET_N(RESET_N), .start(start), .pattern_sel(pattern_sel),
        .ram_in(ram_in), .ram_load(ram_load), .ram_address(ram_address), .ram_out(ram_out),
        .busy(busy), .done(done), .pass(pass), .error_count(error_count),
        .first_fail_addr(first_fail_addr), .first_fail_data(first_fail_data)
    );

    ram512_bist_top u_top (
        .CLK(CLK), .RESET_N(RESET_N), .start(start), .pattern_sel(pattern_sel),
        .busy(top_busy), .done(top_done), .pass(top_pass), .error_count(top_err),
        .first_fail_addr(top_ffa), .first_fail_data(top_ffd)
    );

    // Bench RAM; faults are applied only on the read path while the BIST is reading.
    logic [15:0] mem   [DEPTH];
    logic [15:0] and_m [DEPTH];
    logic [15:0] or_m  [DEPTH];

    always @(posedge CLK) if (ram_load) mem[ram_address] <= ram_in;

    always_comb begin
        ram_out = mem[ram_address];
        if (busy && !ram_load) ram_out = (ram_out & and_m[ram_address]) | or_m[ram_address];
    end

    function automatic logic [15:0] ref_p(input int a, input logic [1:0] s);
        case (s)
            2'd0:    return 16'(a);
            2'd1:    return 16'(65535 - a);
            2'd2:    return (a % 2 == 1) ? 16'h5555 : 16'hAAAA;
            default: return 16'(((a % 256) * 256) + (255 - (a % 256)));
        endcase
    endfunction

    int n_cmp = 0;
    int n_fail = 0;
    int load_cnt = 0, wdata_bad = 0, load_outside = 0;
    logic [1:0] run_sel = 2'd0;

    always @(posedge CLK) begin
        if (ram_load) begin
            load_cnt++;
            if (ram_in !== ref_p(int'(ram_address), run_sel)) wdata_bad++;
            if (!busy) load_outside++;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_faults();
        for (int a = 0; a < DEPTH; a++) begin
            and_m[a] = 16'hFFFF;
            or_m[a]  = 16'h0000;
        end
    endtask

    // kind 0: none, 1: OR mask at faddr, 2: AND mask everywhere, 3: AND mask at faddr
    task automatic apply_fault(input int kind, input int faddr, input logic [15:0] mask);
        clear_faults();
        case (kind)
            1: or_m[faddr] = mask;
            2: for (int a = 0; a < DEPTH; a++) and_m[a] = mask;
            3: and_m[faddr] = mask;
            default: ;
        endcase
    endtask

    task automatic model(input logic [1:0] s, output int e, output int fa, output int fd);
        logic [15:0] obs;
        e = 0; fa = 0; fd = 0;
        for (int a = 0; a < DEPTH; a++) begin
            obs = (ref_p(a, s) & and_m[a]) | or_m[a];
            if (obs != ref_p(a, s)) begin
                if (e == 0) begin
                    fa = a;
                    fd = int'(obs);
                end
                e++;
            end
        end
    endtask

    task automatic run(input string tag, input logic [1:0] sel, input bit noisy, output int lat);
        @(negedge CLK);
        start = 1'b1;
        pattern_sel = sel;
        run_sel = sel;
        load_cnt = 0;
        wdata_bad = 0;
        @(posedge CLK);
        lat = 1;
        #1;
        chk({tag, "_start_cleared_err"}, error_count, 0);
        chk({tag, "_start_busy"}, {busy, done, ram_load}, 3'b101);
        start = 1'b0;
        while (1) begin
            @(posedge CLK);
            lat++;
            #1;
            if (done || lat >= 1200) break;
            if (noisy) start = 1'($urandom_range(0, 1));
            pattern_sel = 2'($urandom);
        end
        start = 1'b0;
    endtask

    task automatic check_run(input string tag, input logic [1:0] sel, input int lat,
                             input int e, input int fa, input int fd, input bit p);
        int bad;
        chk({tag, "_latency"}, lat, EXP_LAT);
        chk({tag, "_err"}, error_count, e);
        chk({tag, "_ffa"}, first_fail_addr, fa);
        chk({tag, "_ffd"}, first_fail_data, fd);
        chk({tag, "_pass"}, pass, p);
        chk({tag, "_busy_done"}, {busy, done, ram_load}, 3'b010);
        chk({tag, "_load_cycles"}, load_cnt, DEPTH);
        chk({tag, "_wdata_bad"}, wdata_bad, 0);
        bad = 0;
        for (int a = 0; a < DEPTH; a++) if (mem[a] !== ref_p(a, sel)) bad++;
        chk({tag, "_ram_content_bad"}, bad, 0);
        chk({tag, "_top_result"}, {top_done, top_pass, top_busy}, 3'b110);
        chk({tag, "_top_stats"}, top_err + top_ffa + top_ffd, 0);
        $display("run %s sel=%0d lat=%0d err=%0d ffa=%0d ffd=%0h pass=%0b",
                 tag, sel, lat, error_count, first_fail_addr, first_fail_data, pass);
    endtask

    typedef struct {
        logic [1:0]  sel;
        int          kind;
        int          faddr;
        logic [15:0] fmask;
        bit          noisy;
        int          exp_err;
        int          exp_ffa;
        int          exp_ffd;
        bit          exp_pass;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int lat, e, fa, fd, nf, hold_err;
        logic [1:0] s;

        vecs[0] = '{2'd0, 0, 0,   16'h0000, 1'b0, 0,   0,   0,     1'b1};
        vecs[1] = '{2'd0, 1, 100, 16'h0008, 1'b0, 1,   100, 108,   1'b0};
        vecs[2] = '{2'd0, 2, 0,   16'hFFFE, 1'b0, 256, 1,   0,     1'b0};
        vecs[3] = '{2'd2, 0, 0,   16'h0000, 1'b1, 0,   0,   0,     1'b1};
        vecs[4] = '{2'd1, 0, 0,   16'h0000, 1'b0, 0,   0,   0,     1'b1};
        vecs[5] = '{2'd3, 1, 0,   16'h8000, 1'b1, 1,   0,   33023, 1'b0};
        vecs[6] = '{2'd1, 3, 511, 16'h0000, 1'b0, 1,   511, 0,     1'b0};

        clear_faults();
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_ctrl", {busy, done, pass, ram_load}, 4'b0000);
        chk("reset_addr_data", ram_address + ram_in, 0);
        chk("reset_stats", error_count + first_fail_addr + first_fail_data, 0);
        @(negedge CLK);
        RESET_N = 1'b1;

        for (int i = 0; i < 7; i++) begin
            apply_fault(vecs[i].kind, vecs[i].faddr, vecs[i].fmask);
            run($sformatf("v%0d", i), vecs[i].sel, vecs[i].noisy, lat);
            check_run($sformatf("v%0d", i), vecs[i].sel, lat, vecs[i].exp_err,
                      vecs[i].exp_ffa, vecs[i].exp_ffd, vecs[i].exp_pass);
        end

        // Results hold in DONE while start stays low.
        hold_err = int'(error_count);
        repeat (5) @(posedge CLK);
        #1;
        chk("hold_done", done, 1);
        chk("hold_err", error_count, hold_err);

        for (int r = 0; r < 4; r++) begin
            clear_faults();
            s = 2'($urandom);
            nf = $urandom_range(0, 6);
            for (int k = 0; k < nf; k++) begin
                if ($urandom_range(0, 1) == 1) or_m[$urandom_range(0, DEPTH - 1)] = 16'($urandom);
                else and_m[$urandom_range(0, DEPTH - 1)] = 16'($urandom);
            end
            if (r == 3) or_m[511] = 16'hFFFF;
            model(s, e, fa, fd);
            run($sformatf("rnd%0d", r), s, 1'b1, lat);
            check_run($sformatf("rnd%0d", r), s, lat, e, fa, fd, e == 0);
        end

        // Reset asserted mid-WRITE, between edges, with the address at 200.
        clear_faults();
        @(negedge CLK);
        start = 1'b1;
        pattern_sel = 2'd0;
        run_sel = 2'd0;
        @(posedge CLK);
        #1;
        start = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (ram_address == 9'd200) break;
            @(posedge CLK);
            #1;
        end
        chk("rst_reached_200", {ram_load, ram_address}, {1'b1, 9'd200});
        #2;
        RESET_N = 1'b0;
        #1;
        chk("rst_mid_ctrl", {busy, done, pass, ram_load}, 4'b0000);
        chk("rst_mid_addr_data", ram_address + ram_in, 0);
        chk("rst_mid_stats", error_count + first_fail_addr + first_fail_data, 0);
        $display("reset mid-write: load=%0b addr=%0d busy=%0b", ram_load, ram_address, busy);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_idle_after_release", {busy, done, ram_load}, 3'b000);
        run("after_rst", 2'd0, 1'b0, lat);
        check_run("after_rst", 2'd0, lat, 0, 0, 0, 1'b1);

        chk("load_outside_busy", load_outside, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
